// File: rtl/riscv_core_scoreboard_nw.sv
// Issue scoreboard: tracks in-flight producers per architectural register and
// derives per-operand bypass selects, ROB tags and issue stalls for a 2-wide bundle.
module riscv_core_scoreboard_nw #(
    parameter int NUM_REGS   = 32,
    parameter int NUM_PIPES  = 2,
    parameter int DEPTH      = 5,
    parameter int TAG_W      = 5,
    parameter int RDY_ALU    = 0,
    parameter int RDY_MEM    = 1,
    parameter int RDY_MULDIV = 3,
    localparam int SEL_W     = $clog2(NUM_PIPES*DEPTH+2),
    localparam int PW        = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1
) (
    input  logic                           clk,
    input  logic                           reset,

    input  logic [4:0]                     src00,
    input  logic [4:0]                     src01,
    input  logic [4:0]                     src10,
    input  logic [4:0]                     src11,
    input  logic                           src00_en,
    input  logic                           src01_en,
    input  logic                           src10_en,
    input  logic                           src11_en,
    input  logic                           src00_renamed,
    input  logic                           src01_renamed,
    input  logic                           src10_renamed,
    input  logic                           src11_renamed,

    input  logic [4:0]                     dst0,
    input  logic [4:0]                     dst1,
    input  logic                           dst0_en,
    input  logic                           dst1_en,
    input  logic [1:0]                     func0,
    input  logic [1:0]                     func1,
    input  logic [PW-1:0]                  pipe0,
    input  logic [PW-1:0]                  pipe1,
    input  logic [TAG_W-1:0]               tag0,
    input  logic [TAG_W-1:0]               tag1,
    input  logic                           ir0_val,
    input  logic                           ir1_val,
    input  logic                           ir0_issued,
    input  logic                           ir1_issued,

    input  logic [NUM_PIPES*DEPTH-1:0]     stall_stage,

    input  logic                           commit1_val,
    input  logic [4:0]                     commit1_reg,
    input  logic [TAG_W-1:0]               commit1_tag,
    input  logic                           commit2_val,
    input  logic [4:0]                     commit2_reg,
    input  logic [TAG_W-1:0]               commit2_tag,

    input  logic                           flush,

    output logic                           stall_ir0,
    output logic                           stall_ir1,
    output logic [SEL_W-1:0]               op00_byp_sel,
    output logic [SEL_W-1:0]               op01_byp_sel,
    output logic [SEL_W-1:0]               op10_byp_sel,
    output logic [SEL_W-1:0]               op11_byp_sel,
    output logic [TAG_W-1:0]               op00_rob_tag,
    output logic [TAG_W-1:0]               op01_rob_tag,
    output logic [TAG_W-1:0]               op10_rob_tag,
    output logic [TAG_W-1:0]               op11_rob_tag
);

    localparam int RW   = 5;
    localparam int NOPS = 4;
    localparam logic [SEL_W-1:0] SEL_ROB = SEL_W'(NUM_PIPES*DEPTH + 1);

    logic              pend_q [NUM_REGS];
    logic [DEPTH-1:0]  pos_q  [NUM_REGS];
    logic [PW-1:0]     pipe_q [NUM_REGS];
    logic [1:0]        func_q [NUM_REGS];
    logic [TAG_W-1:0]  tag_q  [NUM_REGS];

    logic [DEPTH-1:0]  hold_vec [NUM_REGS];
    logic [DEPTH-1:0]  pos_adv  [NUM_REGS];
    logic              clr      [NUM_REGS];

    logic wr0;
    logic wr1;

    // Func 3 returns DEPTH so every in-flight stage blocks.
    function automatic int rdy_of(input logic [1:0] f);
        int r;
        case (f)
            2'b00:   r = RDY_ALU;
            2'b01:   r = RDY_MEM;
            2'b10:   r = RDY_MULDIV;
            default: r = DEPTH;
        endcase
        return r;
    endfunction

    assign wr0 = ir0_issued && dst0_en && (dst0 != '0);
    assign wr1 = ir1_issued && dst1_en && (dst1 != '0);

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            hold_vec[r] = '0;
            for (int p = 0; p < NUM_PIPES; p++) begin
                if (pipe_q[r] == PW'(p)) begin
                    hold_vec[r] = stall_stage[p*DEPTH +: DEPTH];
                end
            end
            // Held bits stay; moving bits shift up, and a bit leaving W falls off.
            pos_adv[r] = (pos_q[r] & hold_vec[r]) | ((pos_q[r] & ~hold_vec[r]) << 1);
            clr[r] = (commit1_val && (commit1_reg == RW'(r)) && (commit1_tag == tag_q[r])) ||
                     (commit2_val && (commit2_reg == RW'(r)) && (commit2_tag == tag_q[r]));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pend_q[r] <= 1'b0;
                pos_q[r]  <= '0;
                pipe_q[r] <= '0;
                func_q[r] <= '0;
                tag_q[r]  <= '0;
            end
        end else if (flush) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pend_q[r] <= 1'b0;
                pos_q[r]  <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (wr1 && (dst1 == RW'(r))) begin
                    pend_q[r] <= 1'b1;
                    pos_q[r]  <= DEPTH'(1);
                    pipe_q[r] <= pipe1;
                    func_q[r] <= func1;
                    tag_q[r]  <= tag1;
                end else if (wr0 && (dst0 == RW'(r))) begin
                    pend_q[r] <= 1'b1;
                    pos_q[r]  <= DEPTH'(1);
                    pipe_q[r] <= pipe0;
                    func_q[r] <= func0;
                    tag_q[r]  <= tag0;
                end else begin
                    pos_q[r] <= pos_adv[r];
                    if (clr[r]) begin
                        pend_q[r] <= 1'b0;
                    end
                end
            end
        end
    end

    logic [RW-1:0]     op_src [NOPS];
    logic              op_en  [NOPS];
    logic              op_ren [NOPS];
    logic [SEL_W-1:0]  sel    [NOPS];
    logic [TAG_W-1:0]  rtag   [NOPS];
    logic              blk    [NOPS];

    assign op_src[0] = src00;
    assign op_src[1] = src01;
    assign op_src[2] = src10;
    assign op_src[3] = src11;
    assign op_en[0]  = src00_en;
    assign op_en[1]  = src01_en;
    assign op_en[2]  = src10_en;
    assign op_en[3]  = src11_en;
    assign op_ren[0] = src00_renamed;
    assign op_ren[1] = src01_renamed;
    assign op_ren[2] = src10_renamed;
    assign op_ren[3] = src11_renamed;

    always_comb begin
        for (int k = 0; k < NOPS; k++) begin
            logic [RW-1:0] a;
            logic          hit;
            int            stg;
            a       = op_src[k];
            stg     = 0;
            sel[k]  = '0;
            rtag[k] = '0;
            blk[k]  = 1'b0;
            hit     = op_ren[k] && (a != '0) && pend_q[a];
            for (int s = 0; s < DEPTH; s++) begin
                if (pos_q[a][s]) begin
                    stg = s;
                end
            end
            if (hit) begin
                rtag[k] = tag_q[a];
                if (pos_q[a] == '0) begin
                    sel[k] = SEL_ROB;
                end else begin
                    sel[k] = SEL_W'(1 + int'(pipe_q[a])*DEPTH + stg);
                    blk[k] = op_en[k] && (stg < rdy_of(func_q[a]));
                end
            end
        end
    end

    logic raw_intra;

    // Slot 1 reading slot 0's destination must wait for slot 0 to issue first.
    assign raw_intra = ir0_val && dst0_en && (dst0 != '0) &&
                       ((src10_renamed && src10_en && (src10 == dst0)) ||
                        (src11_renamed && src11_en && (src11 == dst0)));

    // Gated by reset so stalls drop immediately even though raw_intra is input-driven.
    assign stall_ir0 = reset && ir0_val && (blk[0] || blk[1]);
    assign stall_ir1 = reset && ir1_val && (blk[2] || blk[3] || raw_intra);

    assign op00_byp_sel = sel[0];
    assign op01_byp_sel = sel[1];
    assign op10_byp_sel = sel[2];
    assign op11_byp_sel = sel[3];
    assign op00_rob_tag = rtag[0];
    assign op01_rob_tag = rtag[1];
    assign op10_rob_tag = rtag[2];
    assign op11_rob_tag = rtag[3];

endmodule

// File: tb/tb_riscv_core_scoreboard_nw.sv
// Directed bench for riscv_core_scoreboard_nw: producer tracking, bypass selects,
// stalls, commit, flush and reset, checked against hand-computed values.
module tb_riscv_core_scoreboard_nw;

    localparam int SEL_W = 4;
    localparam int PW    = 1;
    localparam int TAG_W = 5;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] src00, src01, src10, src11;
    logic src00_en, src01_en, src10_en, src11_en;
    logic src00_renamed, src01_renamed, src10_renamed, src11_renamed;
    logic [4:0] dst0, dst1;
    logic dst0_en, dst1_en;
    logic [1:0] func0, func1;
    logic [PW-1:0] pipe0, pipe1;
    logic [TAG_W-1:0] tag0, tag1;
    logic ir0_val, ir1_val, ir0_issued, ir1_issued;
    logic [9:0] stall_stage;
    logic commit1_val, commit2_val;
    logic [4:0] commit1_reg, commit2_reg;
    logic [TAG_W-1:0] commit1_tag, commit2_tag;
    logic flush;
    logic stall_ir0, stall_ir1;
    logic [SEL_W-1:0] op00_byp_sel, op01_byp_sel, op10_byp_sel, op11_byp_sel;
    logic [TAG_W-1:0] op00_rob_tag, op01_rob_tag, op10_rob_tag, op11_rob_tag;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    riscv_core_scoreboard_nw dut (
        .clk(clk), .reset(reset),
        .src00(src00), .src01(src01), .src10(src10), .src11(src11),
        .src00_en(src00_en), .src01_en(src01_en), .src10_en(src10_en), .src11_en(src11_en),
        .src00_renamed(src00_renamed), .src01_renamed(src01_renamed),
        .src10_renamed(src10_renamed), .src11_renamed(src11_renamed),
        .dst0(dst0), .dst1(dst1), .dst0_en(dst0_en), .dst1_en(dst1_en),
        .func0(func0), .func1(func1), .pipe0(pipe0), .pipe1(pipe1),
        .tag0(tag0), .tag1(tag1),
        .ir0_val(ir0_val), .ir1_val(ir1_val), .ir0_issued(ir0_issued), .ir1_issued(ir1_issued),
        .stall_stage(stall_stage),
        .commit1_val(commit1_val), .commit1_reg(commit1_reg), .commit1_tag(commit1_tag),
        .commit2_val(commit2_val), .commit2_reg(commit2_reg), .commit2_tag(commit2_tag),
        .flush(flush),
        .stall_ir0(stall_ir0), .stall_ir1(stall_ir1),
        .op00_byp_sel(op00_byp_sel), .op01_byp_sel(op01_byp_sel),
        .op10_byp_sel(op10_byp_sel), .op11_byp_sel(op11_byp_sel),
        .op00_rob_tag(op00_rob_tag), .op01_rob_tag(op01_rob_tag),
        .op10_rob_tag(op10_rob_tag), .op11_rob_tag(op11_rob_tag)
    );

    task automatic clear_inputs();
        src00 = 0; src01 = 0; src10 = 0; src11 = 0;
        src00_en = 0; src01_en = 0; src10_en = 0; src11_en = 0;
        src00_renamed = 0; src01_renamed = 0; src10_renamed = 0; src11_renamed = 0;
        dst0 = 0; dst1 = 0; dst0_en = 0; dst1_en = 0;
        func0 = 0; func1 = 0; pipe0 = 0; pipe1 = 0; tag0 = 0; tag1 = 0;
        ir0_val = 0; ir1_val = 0; ir0_issued = 0; ir1_issued = 0;
        stall_stage = '0;
        commit1_val = 0; commit1_reg = 0; commit1_tag = 0;
        commit2_val = 0; commit2_reg = 0; commit2_tag = 0;
        flush = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue0(input logic [4:0] d, input logic [1:0] f, input logic p, input logic [4:0] t);
        ir0_val = 1; ir0_issued = 1; dst0 = d; dst0_en = 1; func0 = f; pipe0 = p; tag0 = t;
    endtask

    task automatic issue1(input logic [4:0] d, input logic [1:0] f, input logic p, input logic [4:0] t);
        ir1_val = 1; ir1_issued = 1; dst1 = d; dst1_en = 1; func1 = f; pipe1 = p; tag1 = t;
    endtask

    task automatic read0(input logic [4:0] s);
        ir0_val = 1; src00 = s; src00_en = 1; src00_renamed = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        #1 reset = 0;
        ir0_val = 1; dst0 = 3; dst0_en = 1; read0(3);
        ir1_val = 1; src10 = 3; src10_en = 1; src10_renamed = 1;
        #1;
        total++; if (stall_ir1 !== 1'b0) begin bad++; $display("FAIL reset_stall_ir1: got %0d expected 0", stall_ir1); end
        total++; if (stall_ir0 !== 1'b0) begin bad++; $display("FAIL reset_stall_ir0: got %0d expected 0", stall_ir0); end
        total++; if (op00_byp_sel !== 4'd0) begin bad++; $display("FAIL reset_sel00: got %0d expected 0", op00_byp_sel); end
        total++; if (op10_rob_tag !== 5'd0) begin bad++; $display("FAIL reset_tag10: got %0d expected 0", op10_rob_tag); end
        #1 reset = 1;
        clear_inputs();
        step();
    endtask

    task automatic test_alu_chain();
        int exp_sel[5] = '{2, 3, 4, 5, 11};
        clear_inputs();
        issue0(5, 2'd0, 1'b0, 5'd3);
        step();
        clear_inputs();
        read0(5);
        #1;
        total++; if (op00_byp_sel !== 4'd1) begin bad++; $display("FAIL alu_sel_x0: got %0d expected 1", op00_byp_sel); end
        total++; if (stall_ir0 !== 1'b0) begin bad++; $display("FAIL alu_stall: got %0d expected 0", stall_ir0); end
        total++; if (op00_rob_tag !== 5'd3) begin bad++; $display("FAIL alu_tag: got %0d expected 3", op00_rob_tag); end
        for (int i = 0; i < 5; i++) begin
            step();
            #1;
            total++; if (op00_byp_sel !== SEL_W'(exp_sel[i])) begin bad++; $display("FAIL alu_sel_step%0d: got %0d expected %0d", i, op00_byp_sel, exp_sel[i]); end
            total++; if (stall_ir0 !== 1'b0) begin bad++; $display("FAIL alu_stall_step%0d: got %0d expected 0", i, stall_ir0); end
        end
        total++; if (op00_rob_tag !== 5'd3) begin bad++; $display("FAIL alu_rob_tag: got %0d expected 3", op00_rob_tag); end
        commit1_val = 1; commit1_reg = 5; commit1_tag = 3;
        step();
        commit1_val = 0;
        #1;
        total++; if (op00_byp_sel !== 4'd0) begin bad++; $display("FAIL alu_after_commit_sel: got %0d expected 0", op00_byp_sel); end
        total++; if (op00_rob_tag !== 5'd0) begin bad++; $display("FAIL alu_after_commit_tag: got %0d expected 0", op00_rob_tag); end
    endtask

    task automatic test_muldiv();
        int exp_sel[3] = '{7, 8, 9};
        int exp_stl[3] = '{1, 1, 0};
        int hold_sel[5] = '{7, 7, 7, 8, 9};
        int hold_stl[5] = '{1, 1, 1, 1, 0};
        clear_inputs();
        issue0(7, 2'd2, 1'b1, 5'd7);
        step();
        clear_inputs();
        read0(7);
        #1;
        total++; if (op00_byp_sel !== 4'd6 || stall_ir0 !== 1'b1) begin bad++; $display("FAIL mul_first: got sel=%0d stall=%0d expected sel=6 stall=1", op00_byp_sel, stall_ir0); end
        src00_en = 0;
        #1;
        total++; if (op00_byp_sel !== 4'd6 || stall_ir0 !== 1'b0) begin bad++; $display("FAIL mul_src_disabled: got sel=%0d stall=%0d expected sel=6 stall=0", op00_byp_sel, stall_ir0); end
        src00_en = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            total++; if (op00_byp_sel !== SEL_W'(exp_sel[i]) || stall_ir0 !== 1'(exp_stl[i])) begin bad++; $display("FAIL mul_step%0d: got sel=%0d stall=%0d expected sel=%0d stall=%0d", i, op00_byp_sel, stall_ir0, exp_sel[i], exp_stl[i]); end
        end
        issue0(7, 2'd2, 1'b1, 5'd8);
        step();
        ir0_issued = 0; dst0_en = 0;
        #1;
        total++; if (op00_byp_sel !== 4'd6 || stall_ir0 !== 1'b1 || op00_rob_tag !== 5'd8) begin bad++; $display("FAIL mul_reissue: got sel=%0d stall=%0d tag=%0d expected sel=6 stall=1 tag=8", op00_byp_sel, stall_ir0, op00_rob_tag); end
        stall_stage[6] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            #1;
            total++; if (op00_byp_sel !== SEL_W'(hold_sel[i]) || stall_ir0 !== 1'(hold_stl[i])) begin bad++; $display("FAIL mul_hold_step%0d: got sel=%0d stall=%0d expected sel=%0d stall=%0d", i, op00_byp_sel, stall_ir0, hold_sel[i], hold_stl[i]); end
            if (i == 2) stall_stage[6] = 1'b0;
        end
    endtask

    task automatic test_commit_tag();
        clear_inputs();
        issue0(9, 2'd0, 1'b0, 5'd4);
        step();
        issue0(9, 2'd0, 1'b0, 5'd6);
        step();
        clear_inputs();
        read0(9);
        #1;
        total++; if (op00_byp_sel !== 4'd1 || op00_rob_tag !== 5'd6) begin bad++; $display("FAIL commit_reissue: got sel=%0d tag=%0d expected sel=1 tag=6", op00_byp_sel, op00_rob_tag); end
        commit1_val = 1; commit1_reg = 9; commit1_tag = 4;
        step();
        commit1_val = 0;
        #1;
        total++; if (op00_byp_sel !== 4'd2 || op00_rob_tag !== 5'd6) begin bad++; $display("FAIL commit_stale_tag: got sel=%0d tag=%0d expected sel=2 tag=6", op00_byp_sel, op00_rob_tag); end
        commit2_val = 1; commit2_reg = 9; commit2_tag = 6;
        step();
        commit2_val = 0;
        #1;
        total++; if (op00_byp_sel !== 4'd0 || op00_rob_tag !== 5'd0) begin bad++; $display("FAIL commit_match: got sel=%0d tag=%0d expected sel=0 tag=0", op00_byp_sel, op00_rob_tag); end
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        issue0(12, 2'd0, 1'b0, 5'd1);
        issue1(12, 2'd0, 1'b1, 5'd2);
        step();
        clear_inputs();
        read0(12);
        ir1_val = 1; src10 = 12; src10_en = 1; src10_renamed = 1;
        #1;
        total++; if (op00_byp_sel !== 4'd6 || op00_rob_tag !== 5'd2) begin bad++; $display("FAIL dual_same_dst: got sel=%0d tag=%0d expected sel=6 tag=2", op00_byp_sel, op00_rob_tag); end
        total++; if (op10_byp_sel !== 4'd6 || stall_ir1 !== 1'b0) begin bad++; $display("FAIL dual_slot1_read: got sel=%0d stall=%0d expected sel=6 stall=0", op10_byp_sel, stall_ir1); end
        dst0 = 13; dst0_en = 1;
        src11 = 13; src11_en = 1; src11_renamed = 1;
        #1;
        total++; if (stall_ir1 !== 1'b1 || stall_ir0 !== 1'b0) begin bad++; $display("FAIL intra_raw: got ir0=%0d ir1=%0d expected ir0=0 ir1=1", stall_ir0, stall_ir1); end
        src11_renamed = 0;
        #1;
        total++; if (stall_ir1 !== 1'b0) begin bad++; $display("FAIL intra_not_renamed: got %0d expected 0", stall_ir1); end
    endtask

    task automatic test_unit_classes();
        clear_inputs();
        issue0(14, 2'd1, 1'b0, 5'd9);
        step();
        clear_inputs();
        read0(14);
        #1;
        total++; if (op00_byp_sel !== 4'd1 || stall_ir0 !== 1'b1) begin bad++; $display("FAIL mem_x0: got sel=%0d stall=%0d expected sel=1 stall=1", op00_byp_sel, stall_ir0); end
        step();
        #1;
        total++; if (op00_byp_sel !== 4'd2 || stall_ir0 !== 1'b0) begin bad++; $display("FAIL mem_x1: got sel=%0d stall=%0d expected sel=2 stall=0", op00_byp_sel, stall_ir0); end
        clear_inputs();
        issue1(15, 2'd3, 1'b1, 5'd10);
        step();
        clear_inputs();
        ir1_val = 1; src10 = 15; src10_en = 1; src10_renamed = 1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            #1;
            total++; if (op10_byp_sel !== SEL_W'(6 + i) || stall_ir1 !== (i < 5)) begin bad++; $display("FAIL func3_step%0d: got sel=%0d stall=%0d expected sel=%0d stall=%0d", i, op10_byp_sel, stall_ir1, 6 + i, (i < 5)); end
        end
        total++; if (op10_rob_tag !== 5'd10) begin bad++; $display("FAIL func3_rob_tag: got %0d expected 10", op10_rob_tag); end
    endtask

    task automatic test_x0_nonrenamed();
        clear_inputs();
        issue0(0, 2'd2, 1'b0, 5'd1);
        step();
        clear_inputs();
        read0(0);
        #1;
        total++; if (op00_byp_sel !== 4'd0 || stall_ir0 !== 1'b0 || op00_rob_tag !== 5'd0) begin bad++; $display("FAIL x0_read: got sel=%0d stall=%0d tag=%0d expected all 0", op00_byp_sel, stall_ir0, op00_rob_tag); end
        issue0(16, 2'd2, 1'b0, 5'd2);
        step();
        clear_inputs();
        read0(16);
        src00_renamed = 0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            #1;
            total++; if (op00_byp_sel !== 4'd0 || stall_ir0 !== 1'b0) begin bad++; $display("FAIL not_renamed_step%0d: got sel=%0d stall=%0d expected sel=0 stall=0", i, op00_byp_sel, stall_ir0); end
        end
        src00_renamed = 1;
        #1;
        total++; if (op00_byp_sel !== 4'd3 || stall_ir0 !== 1'b1) begin bad++; $display("FAIL renamed_control: got sel=%0d stall=%0d expected sel=3 stall=1", op00_byp_sel, stall_ir0); end
    endtask

    task automatic test_flush();
        clear_inputs();
        issue0(1, 2'd0, 1'b0, 5'd1);
        issue1(2, 2'd0, 1'b1, 5'd2);
        step();
        issue0(3, 2'd0, 1'b0, 5'd3);
        issue1(4, 2'd0, 1'b1, 5'd4);
        step();
        clear_inputs();
        read0(1);
        #1;
        total++; if (op00_byp_sel !== 4'd2) begin bad++; $display("FAIL flush_pre: got %0d expected 2", op00_byp_sel); end
        flush = 1;
        issue0(20, 2'd0, 1'b0, 5'd5);
        step();
        clear_inputs();
        ir0_val = 1; ir1_val = 1;
        src00 = 1;  src00_en = 1; src00_renamed = 1;
        src01 = 3;  src01_en = 1; src01_renamed = 1;
        src10 = 4;  src10_en = 1; src10_renamed = 1;
        src11 = 20; src11_en = 1; src11_renamed = 1;
        #1;
        total++; if (op00_byp_sel !== 4'd0 || op01_byp_sel !== 4'd0 || op10_byp_sel !== 4'd0) begin bad++; $display("FAIL flush_sels: got %0d %0d %0d expected 0 0 0", op00_byp_sel, op01_byp_sel, op10_byp_sel); end
        total++; if (op11_byp_sel !== 4'd0 || op11_rob_tag !== 5'd0) begin bad++; $display("FAIL flush_no_new_entry: got sel=%0d tag=%0d expected 0 0", op11_byp_sel, op11_rob_tag); end
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        issue0(17, 2'd0, 1'b0, 5'd3);
        step();
        clear_inputs();
        read0(17);
        dst0 = 17; dst0_en = 1;
        ir1_val = 1; src10 = 17; src10_en = 1; src10_renamed = 1;
        #1;
        total++; if (op00_byp_sel !== 4'd1 || stall_ir1 !== 1'b1) begin bad++; $display("FAIL rstmid_pre: got sel=%0d stall1=%0d expected sel=1 stall1=1", op00_byp_sel, stall_ir1); end
        #1 reset = 0;
        #1;
        total++; if (op00_byp_sel !== 4'd0 || op00_rob_tag !== 5'd0 || stall_ir0 !== 1'b0 || stall_ir1 !== 1'b0) begin bad++; $display("FAIL rstmid_async: got sel=%0d tag=%0d s0=%0d s1=%0d expected all 0", op00_byp_sel, op00_rob_tag, stall_ir0, stall_ir1); end
        #1 reset = 1;
        step();
        #1;
        total++; if (op00_byp_sel !== 4'd0 || stall_ir1 !== 1'b1) begin bad++; $display("FAIL rstmid_post: got sel=%0d stall1=%0d expected sel=0 stall1=1", op00_byp_sel, stall_ir1); end
    endtask

    initial begin
        test_reset();
        test_alu_chain();
        test_muldiv();
        test_commit_tag();
        test_back_to_back();
        test_unit_classes();
        test_x0_nonrenamed();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_core_scoreboard_nw.md
# riscv_core_scoreboard_nw

Parametrised issue scoreboard for the IO2I RISC-V core. It sits between the issue stage and the execution pipelines. For every architectural register it tracks:
- the in-flight producer's pipeline, stage position, functional-unit class and ROB tag;
- from that state, per-operand stall and bypass-mux selects for a 2-wide issue bundle.

Compared with the fixed 2-pipe scoreboard, pipe count, stage depth and per-class ready stages are parameters. It also adds tag-qualified commit, full flush and intra-bundle RAW detection.

## Interface
- NUM_REGS, 32, architectural registers tracked; x0 is never tracked.
- NUM_PIPES, 2, execution pipelines (A=0, B=1, ...).
- DEPTH, 5, bypassable stages per pipe: X0..X(DEPTH-2), then W. Range 2..8.
- TAG_W, 5, ROB tag width.
- RDY_ALU / RDY_MEM / RDY_MULDIV, 0 / 1 / 3, first stage index whose result is bypassable for each class (func 2'b00 / 2'b01 / 2'b10). Func 2'b11 is never bypassable in flight.
- Derived: SEL_W = clog2(NUM_PIPES*DEPTH+2); PW = max(1, clog2(NUM_PIPES)).

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- srcK0, srcK1  in  5  source register addresses for slot K (K=0,1).
- srcK0_en, srcK1_en  in  1  source is read.
- srcK0_renamed, srcK1_renamed  in  1  source may have an in-flight producer.
- dstK  in  5  destination register of slot K.
- dstK_en  in  1  slot K writes a register.
- funcK  in  2  unit class of slot K.
- pipeK  in  PW  pipe that slot K is steered to.
- tagK  in  TAG_W  ROB tag allocated to slot K.
- irK_val  in  1  slot K holds a valid candidate.
- irK_issued  in  1  slot K issues this cycle.
- stall_stage  in  NUM_PIPES*DEPTH  per-pipe, per-stage hold; bit p*DEPTH+s holds pipe p, stage s.
- commitJ_val  in  1  ROB commit port J (J=1,2) is valid.
- commitJ_reg  in  5  register written by commit port J.
- commitJ_tag  in  TAG_W  tag committed on port J.
- flush  in  1  squash all in-flight state.
- stall_ir0, stall_ir1  out  1  slot cannot issue.
- opKx_byp_sel  out  SEL_W  bypass select for each operand (x=0,1).
- opKx_rob_tag  out  TAG_W  tag of the producer to read from the ROB.

## Operation
Per-register state:
- pend: producer not yet committed.
- pos: one-hot of DEPTH bits; all-zero means the producer has left W and the value is in the ROB.
- pipe, func, tag of the producer.

Issue, on each posedge:
- A slot records state when irK_issued && dstK_en && dstK != 0.
- Recorded state: pend=1, pos=bit0 (X0), pipe=pipeK, func=funcK, tag=tagK.
- If both slots issue to the same dst, slot 1 (younger) wins.

Advance, for entries not being written by issue:
- A pos bit at stage s of pipe p holds if stall_stage[p*DEPTH+s] is set, otherwise moves to s+1.
- A bit leaving W clears, so pos becomes 0.

Commit:
- pend[r] clears when a valid commit port carries reg r and the tag equals the stored tag[r].
- A tag mismatch (the register was re-issued since) leaves pend set.
- Issue to r in the same cycle as a commit to r: issue wins.

Flush:
- Clears all pend and pos at the next edge.
- Issue in the same cycle as flush is ignored.

Bypass select, combinational from registered state:
- hit = src_renamed && pend[src] && src != 0.
- hit && pos bit s set, producer pipe p → sel = 1 + p*DEPTH + s.
- hit && pos == 0 → sel = NUM_PIPES*DEPTH+1 (ROB).
- Otherwise sel = 0 (register file).
- opKx_rob_tag = tag[src] whenever hit; 0 otherwise.
- Defaults give: 0 = RF, 1..5 = AX0..AW, 6..10 = BX0..BW, 11 = ROB.

Stall:
- An operand blocks when hit && src_en && pos != 0 && stage index < RDY of its func class.
- Func 3 blocks for any pos != 0.
- stall_irK = irK_val && (either operand of slot K blocks).
- stall_ir1 additionally asserts when ir0_val && dst0_en && dst0 != 0 and a renamed, enabled slot-1 source equals dst0 (intra-bundle RAW).
- Slot 0 never stalls on slot 1.

## Timing
- Outputs are combinational from registered state and current inputs: zero-cycle lookup.
- State updates on posedge clk only.
- An issue at edge n is visible to lookups in cycle n+1 with sel = X0 of the issuing pipe.
- With no stalls, the producer reaches W at cycle n+DEPTH and the ROB select at n+DEPTH+1.
- Reset asserted, immediately regardless of clk:
  - all pend, pos, pipe, func and tag = 0;
  - every stall output = 0, every sel = 0, every rob_tag = 0.
- Reset mid-operation discards all in-flight entries.
- The first edge after reset deasserts behaves as a clean state.

## Test plan
- ALU chain: slot 0 issues x5 (pipe A, func 0, tag 3); the next cycle slot 0 reads x5 → stall_ir0=0, sel=1 (AX0); the following cycles give 2, 3, 4, 5, then 11 with rob_tag=3.
- MULDIV latency: issue x7 func 2 on pipe B; dependent read → stall until pos reaches X3 (cycle n+4, sel=9), then stall=0. Hold stall_stage bit B.X1 for 2 cycles → stall extends by 2 cycles.
- Tag-qualified commit: issue x9 tag 4, then x9 tag 6. commit1 (x9, tag 4) → pend stays 1. commit2 (x9, tag 6) → pend clears and sel=0.
- Same-dst dual issue: both slots write x12 with tags 1 and 2 on pipes A and B → tag=2, sel=6 next cycle. Intra-bundle: slot 1 src = slot 0 dst → stall_ir1=1, stall_ir0=0.
- Flush and reset: fill 4 entries, assert flush with a concurrent issue → all sels 0 next cycle and no new entry. Drop reset mid-run → outputs 0 asynchronously.
- x0 and non-renamed sources: issue to x0 or read with renamed=0 → sel=0, no stall, in all cycles.
